mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one backing-memory port between the instruction-fetch requester (I, read-only) and the
//  load/store requester (D, read/write with byte enables). Sits between the fetch/memory stages and
//  the memory/bus side. Uses the same level-req / single-cycle-valid handshake on both sides.
//  Latches the winning request and runs it to completion. Flags a sticky error if the memory hangs.
// PARAMETERS
//  TIMEOUT   256  cycles in a GRANT state without m_rvalid/m_wvalid before abort; 0 = timer disabled
//  AW        32   address width
// PORTS
//  clk             in   1   clock (single clock domain)
//  rst             in   1   reset, asynchronous, active-high
//  i_addr          in   AW  fetch address
//  i_rreq          in   1   fetch read request, level; held until i_rvalid
//  i_rdata         out  32  fetch read data, qualified by i_rvalid
//  i_rvalid        out  1   fetch completion pulse, 1 cycle
//  d_addr          in   AW  load/store address
//  d_wreq          in   1   store request, level; held until d_wvalid
//  d_rreq          in   1   load request, level; held until d_rvalid
//  d_wdata         in   32  store data
//  d_byte_enable   in   4   store/load byte lanes
//  d_rdata         out  32  load data, qualified by d_rvalid
//  d_rvalid        out  1   load completion pulse, 1 cycle
//  d_wvalid        out  1   store completion pulse, 1 cycle
//  m_addr          out  AW  memory address (registered)
//  m_wreq          out  1   memory write request (registered level)
//  m_rreq          out  1   memory read request (registered level)
//  m_wdata         out  32  memory write data (registered)
//  m_byte_enable   out  4   memory byte lanes (registered; 4'b1111 for I reads)
//  m_rdata         in   32  memory read data
//  m_rvalid        in   1   memory read completion pulse
//  m_wvalid        in   1   memory write completion pulse
//  timeout_err     out  1   sticky; set on abort, cleared only by rst
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0. This includes every m_* output, both *valid pulses, timeout_err and last_grant.
//  - FSM states: IDLE, GNT_I, GNT_D.
//  - IDLE transitions: any req sampled high -> winner's addr/wdata/be/op latched into m_* regs.
//    Next state is GNT_I or GNT_D. m_*req is high from the next cycle.
//  - GNT_x: m_* held stable. Exit to IDLE on the first matching m_rvalid/m_wvalid.
//  - Completion: in that same cycle, the owner's *valid pulses for 1 cycle. *_rdata = m_rdata, combinational.
//    The same edge clears m_wreq/m_rreq.
//  - Latency: request at cycle N -> m_*req at N+1. Completion at M -> requester valid at M; IDLE at M+1.
//    Next grant is issued at M+1, and its m_*req is visible at M+2.
//  - Non-owner valid outputs stay 0. A stray m_*valid in IDLE or of the wrong type is ignored.
//  - Requester drops req mid-transaction: the transaction still completes and the valid pulse is still issued.
//  - d_wreq and d_rreq both high: treated as a store; d_rreq is ignored for that grant.
//  - Timer: counts cycles in GNT_x. Reaching TIMEOUT -> owner's valid pulses, rdata forced to 0,
//    timeout_err <= 1, state -> IDLE. The timer resets on every grant.
//  - Arbitration when both are pending in IDLE: see CONFIGURATION. A lone requester always wins.
//  - Async rst mid-transaction: abandons it immediately. No valid pulse is issued; m_*req drops asynchronously.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin. last_grant updates on each grant; on a tie, the port not granted last wins.
//  After reset, last_grant = I, so D wins the first tie.
//  MEM_ARB_RR_EN undefined: fixed priority, D always wins a tie (older instruction). last_grant is not built.
// STRUCTURE
//  mem_arb_pkg: state encoding (IDLE/GNT_I/GNT_D), port IDs (PORT_I=0, PORT_D=1), BE_WORD=4'b1111.
//  Sub-module mem_arb_timer: load/count/expire counter, clog2(TIMEOUT+1) bits; tied off when TIMEOUT=0.
// TESTING
//  1 D store addr=0x100 wdata=0xDEADBEEF be=4'b0011, mem wvalid 3 cycles after m_wreq:
//    m_* match the inputs; d_wvalid is 1 cycle, coincident with m_wvalid.
//  2 I read 0x40, mem returns 0x00000013: i_rvalid=1 for 1 cycle, i_rdata=0x13.
//    m_byte_enable=4'b1111; d_rvalid stays 0.
//  3 I and D reqs rise the same cycle, repeated twice back-to-back:
//    fixed priority -> D,I,D,I serviced (each re-requests); RR -> D,I,D,I serviced with I always held high.
//  4 TIMEOUT=8, D load with no m_rvalid: d_rvalid at the 8th grant cycle with d_rdata=0.
//    timeout_err=1 and remains 1; the next I request is served normally.
//  5 rst asserted 2 cycles into GNT_D: m_rreq=0 asynchronously, no d_rvalid, state IDLE.
//    After release, a new I request is granted.
//  6 m_rvalid pulsed in IDLE and m_wvalid during a read grant: no requester valid, no state change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the I/D memory-port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_id_t;

    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - fetch, load/store and memory-side signals of the arbiter
interface mem_arb_if #(
    parameter int AW = 32
);
    logic [AW-1:0] i_addr;
    logic          i_rreq;
    logic [31:0]   i_rdata;
    logic          i_rvalid;

    logic [AW-1:0] d_addr;
    logic          d_wreq;
    logic          d_rreq;
    logic [31:0]   d_wdata;
    logic [3:0]    d_byte_enable;
    logic [31:0]   d_rdata;
    logic          d_rvalid;
    logic          d_wvalid;

    logic [AW-1:0] m_addr;
    logic          m_wreq;
    logic          m_rreq;
    logic [31:0]   m_wdata;
    logic [3:0]    m_byte_enable;
    logic [31:0]   m_rdata;
    logic          m_rvalid;
    logic          m_wvalid;

    logic          timeout_err;

    // Arbiter view.
    modport slave (
        input  i_addr, i_rreq, d_addr, d_wreq, d_rreq, d_wdata, d_byte_enable,
        input  m_rdata, m_rvalid, m_wvalid,
        output i_rdata, i_rvalid, d_rdata, d_rvalid, d_wvalid,
        output m_addr, m_wreq, m_rreq, m_wdata, m_byte_enable, timeout_err
    );

    // Requester and memory view.
    modport master (
        output i_addr, i_rreq, d_addr, d_wreq, d_rreq, d_wdata, d_byte_enable,
        output m_rdata, m_rvalid, m_wvalid,
        input  i_rdata, i_rvalid, d_rdata, d_rvalid, d_wvalid,
        input  m_addr, m_wreq, m_rreq, m_wdata, m_byte_enable, timeout_err
    );
endinterface

// File: rtl/mem_arb_timer.sv
// rtl/mem_arb_timer.sv - grant watchdog: load on grant, count while granted, expire at TIMEOUT
module mem_arb_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);
    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    generate
        if (TIMEOUT > 0) begin : g_timer
            logic [W-1:0] cnt;

            // Load with 1 so the first granted cycle is cycle 1.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                end else if (load) begin
                    cnt <= W'(1);
                end else if (en) begin
                    cnt <= cnt + W'(1);
                end
            end

            assign expire = en && (cnt == W'(TIMEOUT));
        end else begin : g_tieoff
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk, rst, load, en};
            assign expire        = 1'b0;
        end
    endgenerate
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between fetch and load/store requesters
// Optional: MEM_ARB_RR_EN selects round-robin tie-break instead of fixed D priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int AW      = 32
) (
    input  logic      clk,
    input  logic      rst,
    mem_arb_if.slave  bus
);
    arb_state_t    state, state_nxt;
    logic          d_req, pick_d, pick_i, grant;
    logic          done, expire, finish;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          wreq_q, rreq_q, err_q;
    logic [31:0]   rdata_mux;

    assign d_req = bus.d_wreq | bus.d_rreq;

`ifdef MEM_ARB_RR_EN
    port_id_t last_grant;

    assign pick_d = d_req && (!bus.i_rreq || (last_grant == PORT_I));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PORT_I;
        end else if (grant) begin
            last_grant <= pick_d ? PORT_D : PORT_I;
        end
    end
`else
    assign pick_d = d_req;
`endif

    assign pick_i = bus.i_rreq && !pick_d;
    assign grant  = (state == IDLE) && (pick_i || pick_d);

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (grant),
        .en     (state != IDLE),
        .expire (expire)
    );

    // Only the response type matching the latched operation completes a grant.
    always_comb begin
        done = 1'b0;
        case (state)
            GNT_I:   done = bus.m_rvalid;
            GNT_D:   done = wreq_q ? bus.m_wvalid : bus.m_rvalid;
            default: done = 1'b0;
        endcase
    end

    assign finish = done | expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    state_nxt = GNT_D;
                end else if (pick_i) begin
                    state_nxt = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (finish) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wreq_q  <= 1'b0;
            rreq_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (grant) begin
                if (pick_d) begin
                    // A simultaneous store and load is run as the store.
                    addr_q  <= bus.d_addr;
                    wdata_q <= bus.d_wdata;
                    be_q    <= bus.d_byte_enable;
                    wreq_q  <= bus.d_wreq;
                    rreq_q  <= !bus.d_wreq;
                end else begin
                    addr_q  <= bus.i_addr;
                    wdata_q <= '0;
                    be_q    <= BE_WORD;
                    wreq_q  <= 1'b0;
                    rreq_q  <= 1'b1;
                end
            end else if (finish) begin
                wreq_q <= 1'b0;
                rreq_q <= 1'b0;
            end
            if (expire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rdata_mux = expire ? 32'h0 : bus.m_rdata;

    assign bus.i_rdata       = rdata_mux;
    assign bus.d_rdata       = rdata_mux;
    assign bus.i_rvalid      = (state == GNT_I) && finish;
    assign bus.d_rvalid      = (state == GNT_D) && finish && !wreq_q;
    assign bus.d_wvalid      = (state == GNT_D) && finish && wreq_q;
    assign bus.m_addr        = addr_q;
    assign bus.m_wdata       = wdata_q;
    assign bus.m_byte_enable = be_q;
    assign bus.m_wreq        = wreq_q;
    assign bus.m_rreq        = rreq_q;
    assign bus.timeout_err   = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (TIMEOUT=8)
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mem_arb_if #(.AW(32)) bus ();

    mem_arbiter #(.TIMEOUT(8), .AW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_addr = '0; bus.i_rreq = 1'b0;
        bus.d_addr = '0; bus.d_wreq = 1'b0; bus.d_rreq = 1'b0;
        bus.d_wdata = '0; bus.d_byte_enable = '0;
        bus.m_rdata = '0; bus.m_rvalid = 1'b0; bus.m_wvalid = 1'b0;
        tick(); tick(); mid();
        vectors++;
        if ({bus.m_wreq, bus.m_rreq, bus.i_rvalid, bus.d_rvalid, bus.d_wvalid, bus.timeout_err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 000000",
                     {bus.m_wreq, bus.m_rreq, bus.i_rvalid, bus.d_rvalid, bus.d_wvalid, bus.timeout_err});
        end
        vectors++;
        if ({bus.m_addr, bus.m_wdata, bus.m_byte_enable} !== 68'h0) begin
            miscompares++;
            $display("FAIL reset_m_regs got %h want 0", {bus.m_addr, bus.m_wdata, bus.m_byte_enable});
        end
        vectors++;
        if (dut.state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_state got %0d want %0d", dut.state, IDLE);
        end
        rst = 1'b0;
    endtask

    task automatic test_store();
        tick();
        bus.d_addr = 32'h100; bus.d_wdata = 32'hDEADBEEF; bus.d_byte_enable = 4'b0011; bus.d_wreq = 1'b1;
        mid();
        vectors++;
        if (bus.m_wreq !== 1'b0) begin
            miscompares++;
            $display("FAIL store_req_early got %b want 0", bus.m_wreq);
        end
        tick(); mid();
        vectors++;
        if ({bus.m_wreq, bus.m_rreq, bus.m_addr, bus.m_wdata, bus.m_byte_enable} !== {2'b10, 32'h100, 32'hDEADBEEF, 4'b0011}) begin
            miscompares++;
            $display("FAIL store_m_regs got %h want %h",
                     {bus.m_wreq, bus.m_rreq, bus.m_addr, bus.m_wdata, bus.m_byte_enable},
                     {2'b10, 32'h100, 32'hDEADBEEF, 4'b0011});
        end
        for (int k = 0; k < 2; k++) begin
            tick(); mid();
            vectors++;
            if (bus.d_wvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL store_wvalid_early got %b want 0", bus.d_wvalid);
            end
        end
        tick();
        bus.m_wvalid = 1'b1;
        mid();
        vectors++;
        if ({bus.d_wvalid, bus.d_rvalid, bus.i_rvalid} !== 3'b100) begin
            miscompares++;
            $display("FAIL store_done got %b want 100", {bus.d_wvalid, bus.d_rvalid, bus.i_rvalid});
        end
        tick();
        bus.m_wvalid = 1'b0; bus.d_wreq = 1'b0;
        mid();
        vectors++;
        if ({bus.d_wvalid, bus.m_wreq, dut.state} !== {2'b00, IDLE}) begin
            miscompares++;
            $display("FAIL store_after got %b want 0000", {bus.d_wvalid, bus.m_wreq, dut.state});
        end
    endtask

    task automatic test_store_wins_over_load();
        tick();
        bus.d_addr = 32'h180; bus.d_wdata = 32'h0BADF00D; bus.d_byte_enable = 4'b1100;
        bus.d_wreq = 1'b1; bus.d_rreq = 1'b1;
        tick(); mid();
        vectors++;
        if ({bus.m_wreq, bus.m_rreq} !== 2'b10) begin
            miscompares++;
            $display("FAIL both_req_op got %b want 10", {bus.m_wreq, bus.m_rreq});
        end
        tick();
        bus.m_wvalid = 1'b1;
        mid();
        vectors++;
        if ({bus.d_wvalid, bus.d_rvalid} !== 2'b10) begin
            miscompares++;
            $display("FAIL both_req_done got %b want 10", {bus.d_wvalid, bus.d_rvalid});
        end
        tick();
        bus.m_wvalid = 1'b0; bus.d_wreq = 1'b0; bus.d_rreq = 1'b0;
    endtask

    task automatic test_iread();
        tick();
        bus.i_addr = 32'h40; bus.i_rreq = 1'b1;
        tick(); mid();
        vectors++;
        if ({bus.m_rreq, bus.m_wreq, bus.m_addr, bus.m_byte_enable} !== {2'b10, 32'h40, 4'b1111}) begin
            miscompares++;
            $display("FAIL iread_m_regs got %h want %h",
                     {bus.m_rreq, bus.m_wreq, bus.m_addr, bus.m_byte_enable}, {2'b10, 32'h40, 4'b1111});
        end
        tick();
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'h00000013;
        mid();
        vectors++;
        if ({bus.i_rvalid, bus.d_rvalid, bus.i_rdata} !== {2'b10, 32'h13}) begin
            miscompares++;
            $display("FAIL iread_done got %h want %h", {bus.i_rvalid, bus.d_rvalid, bus.i_rdata}, {2'b10, 32'h13});
        end
        tick();
        bus.m_rvalid = 1'b0; bus.i_rreq = 1'b0;
        mid();
        vectors++;
        if ({bus.i_rvalid, bus.m_rreq} !== 2'b00) begin
            miscompares++;
            $display("FAIL iread_after got %b want 00", {bus.i_rvalid, bus.m_rreq});
        end
    endtask

    task automatic test_back_to_back();
        tick();
        bus.i_addr = 32'h200; bus.i_rreq = 1'b1;
        bus.d_addr = 32'h300; bus.d_rreq = 1'b1; bus.d_byte_enable = 4'b1111;
        for (int r = 0; r < 2; r++) begin
            tick(); mid();
            vectors++;
            if ({bus.m_rreq, bus.m_addr} !== {1'b1, 32'h300}) begin
                miscompares++;
                $display("FAIL tie%0d_d_grant got %h want %h", r, {bus.m_rreq, bus.m_addr}, {1'b1, 32'h300});
            end
            tick();
            bus.m_rvalid = 1'b1; bus.m_rdata = 32'hD0 + r;
            mid();
            vectors++;
            if ({bus.d_rvalid, bus.i_rvalid, bus.d_rdata} !== {2'b10, 32'hD0 + r}) begin
                miscompares++;
                $display("FAIL tie%0d_d_done got %h want %h", r,
                         {bus.d_rvalid, bus.i_rvalid, bus.d_rdata}, {2'b10, 32'hD0 + r});
            end
            tick();
            bus.m_rvalid = 1'b0; bus.d_rreq = 1'b0;
            tick(); mid();
            vectors++;
            if ({bus.m_rreq, bus.m_addr} !== {1'b1, 32'h200}) begin
                miscompares++;
                $display("FAIL tie%0d_i_grant got %h want %h", r, {bus.m_rreq, bus.m_addr}, {1'b1, 32'h200});
            end
            tick();
            bus.m_rvalid = 1'b1; bus.m_rdata = 32'h1A + r;
            mid();
            vectors++;
            if ({bus.i_rvalid, bus.d_rvalid, bus.i_rdata} !== {2'b10, 32'h1A + r}) begin
                miscompares++;
                $display("FAIL tie%0d_i_done got %h want %h", r,
                         {bus.i_rvalid, bus.d_rvalid, bus.i_rdata}, {2'b10, 32'h1A + r});
            end
            tick();
            bus.m_rvalid = 1'b0;
            if (r == 0) bus.d_rreq = 1'b1;
            else        bus.i_rreq = 1'b0;
        end
    endtask

    task automatic test_timeout();
        tick();
        bus.d_addr = 32'h500; bus.d_byte_enable = 4'b0101; bus.d_rreq = 1'b1; bus.m_rdata = 32'hFFFFFFFF;
        tick();
        for (int k = 1; k < 8; k++) begin
            mid();
            vectors++;
            if (bus.d_rvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_early_c%0d got %b want 0", k, bus.d_rvalid);
            end
            tick();
        end
        mid();
        vectors++;
        if ({bus.d_rvalid, bus.d_wvalid, bus.d_rdata} !== {2'b10, 32'h0}) begin
            miscompares++;
            $display("FAIL timeout_abort got %h want %h", {bus.d_rvalid, bus.d_wvalid, bus.d_rdata}, {2'b10, 32'h0});
        end
        tick();
        bus.d_rreq = 1'b0;
        mid();
        vectors++;
        if ({bus.timeout_err, bus.m_rreq, bus.d_rvalid, dut.state} !== {3'b100, IDLE}) begin
            miscompares++;
            $display("FAIL timeout_after got %b want 10000", {bus.timeout_err, bus.m_rreq, bus.d_rvalid, dut.state});
        end
        tick();
        bus.i_addr = 32'h44; bus.i_rreq = 1'b1; bus.m_rdata = 32'h1234;
        tick(); mid();
        vectors++;
        if ({bus.m_rreq, bus.m_addr} !== {1'b1, 32'h44}) begin
            miscompares++;
            $display("FAIL timeout_next_grant got %h want %h", {bus.m_rreq, bus.m_addr}, {1'b1, 32'h44});
        end
        tick();
        bus.m_rvalid = 1'b1;
        mid();
        vectors++;
        if ({bus.i_rvalid, bus.timeout_err, bus.i_rdata} !== {2'b11, 32'h1234}) begin
            miscompares++;
            $display("FAIL timeout_next_done got %h want %h", {bus.i_rvalid, bus.timeout_err, bus.i_rdata}, {2'b11, 32'h1234});
        end
        tick();
        bus.m_rvalid = 1'b0; bus.i_rreq = 1'b0;
    endtask

    task automatic test_async_reset();
        tick();
        bus.d_addr = 32'h600; bus.d_rreq = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.m_rreq, bus.d_rvalid, bus.timeout_err, dut.state} !== {3'b000, IDLE}) begin
            miscompares++;
            $display("FAIL arst_abandon got %b want 00000", {bus.m_rreq, bus.d_rvalid, bus.timeout_err, dut.state});
        end
        #2;
        bus.d_rreq = 1'b0;
        rst = 1'b0;
        tick();
        bus.i_addr = 32'h80; bus.i_rreq = 1'b1;
        tick(); mid();
        vectors++;
        if ({bus.m_rreq, bus.m_addr, bus.m_byte_enable} !== {1'b1, 32'h80, 4'b1111}) begin
            miscompares++;
            $display("FAIL arst_regrant got %h want %h", {bus.m_rreq, bus.m_addr, bus.m_byte_enable}, {1'b1, 32'h80, 4'b1111});
        end
        tick();
        bus.m_rvalid = 1'b1;
        mid();
        vectors++;
        if (bus.i_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_regrant_done got %b want 1", bus.i_rvalid);
        end
        tick();
        bus.m_rvalid = 1'b0; bus.i_rreq = 1'b0;
    endtask

    task automatic test_stray_valid();
        tick();
        bus.m_rvalid = 1'b1;
        mid();
        vectors++;
        if ({bus.i_rvalid, bus.d_rvalid, bus.d_wvalid} !== 3'b000) begin
            miscompares++;
            $display("FAIL stray_idle got %b want 000", {bus.i_rvalid, bus.d_rvalid, bus.d_wvalid});
        end
        tick();
        bus.m_rvalid = 1'b0;
        mid();
        vectors++;
        if ({bus.m_rreq, dut.state} !== {1'b0, IDLE}) begin
            miscompares++;
            $display("FAIL stray_idle_state got %b want 000", {bus.m_rreq, dut.state});
        end
        tick();
        bus.d_addr = 32'h700; bus.d_rreq = 1'b1;
        tick();
        tick();
        bus.m_wvalid = 1'b1;
        mid();
        vectors++;
        if ({bus.d_rvalid, bus.d_wvalid, bus.i_rvalid} !== 3'b000) begin
            miscompares++;
            $display("FAIL stray_wrong_type got %b want 000", {bus.d_rvalid, bus.d_wvalid, bus.i_rvalid});
        end
        tick();
        bus.m_wvalid = 1'b0;
        mid();
        vectors++;
        if ({bus.m_rreq, dut.state} !== {1'b1, GNT_D}) begin
            miscompares++;
            $display("FAIL stray_hold got %b want %b", {bus.m_rreq, dut.state}, {1'b1, GNT_D});
        end
        tick();
        bus.m_rvalid = 1'b1;
        mid();
        vectors++;
        if (bus.d_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL stray_real_done got %b want 1", bus.d_rvalid);
        end
        tick();
        bus.m_rvalid = 1'b0; bus.d_rreq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store();
        test_store_wins_over_load();
        test_iread();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        test_stray_valid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
